// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_ctrl_pkg
//  Purpose  : Shared opcode constants, state/class enums and aluop codes for
//             the RV32I multicycle control sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;

    localparam logic [6:0] c_HALT_OPCODE = 7'h7f;

    localparam logic [1:0] c_ALUOP_ADD = 2'b00;
    localparam logic [1:0] c_ALUOP_BR  = 2'b01;
    localparam logic [1:0] c_ALUOP_R   = 2'b10;
    localparam logic [1:0] c_ALUOP_I   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_R     = 3'd0,
        CLS_I     = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_BR    = 3'd4,
        CLS_JAL   = 3'd5,
        CLS_JALR  = 3'd6,
        CLS_ILL   = 3'd7
    } cls_t;

endpackage
`default_nettype wire

// File: rtl/mc_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_unit_if
//  Purpose  : Control bundle between the sequencer (master) and the shared
//             datapath / memory port (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface mc_control_unit_if #(
    parameter int OPCODE_W = 7,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 32
);
    logic                start;
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                ir_write;
    logic                pc_write;
    logic                branch;
    logic                alu_src;
    logic [ALUOP_W-1:0]  aluop;
    logic                reg_write;
    logic                mem_to_reg;
    logic                busy;
    logic                halted;
    logic                err_illegal;
    logic                err_timeout;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        input  start, opcode, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, branch, alu_src, aluop,
               reg_write, mem_to_reg, busy, halted, err_illegal, err_timeout,
               instr_count
    );

    modport slave (
        output start, opcode, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, branch, alu_src, aluop,
               reg_write, mem_to_reg, busy, halted, err_illegal, err_timeout,
               instr_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_class_decode.sv
`default_nettype none
// ============================================================================
//  Module   : instr_class_decode
//  Purpose  : Combinational opcode to instruction-class decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_class_decode
    import rv_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7
) (
    input  wire logic [OPCODE_W-1:0] i_opcode,
    output cls_t                     o_cls
);

    // Map each supported major opcode to its class; anything else is illegal.
    always_comb begin
        o_cls = CLS_ILL;
        case (i_opcode)
            c_OP_R:     o_cls = CLS_R;
            c_OP_I:     o_cls = CLS_I;
            c_OP_LOAD:  o_cls = CLS_LOAD;
            c_OP_STORE: o_cls = CLS_STORE;
            c_OP_BR:    o_cls = CLS_BR;
            c_OP_JAL:   o_cls = CLS_JAL;
            c_OP_JALR:  o_cls = CLS_JALR;
            default:    o_cls = CLS_ILL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_unit
//  Purpose  : Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory
//             handshake, halt, illegal-opcode and memory-timeout detection.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int                  OPCODE_W    = 7,
    parameter int                  ALUOP_W     = 2,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = c_HALT_OPCODE,
    parameter int                  MEM_TIMEOUT = 16,
    parameter int                  CNT_W       = 32
) (
    input wire logic             clk,
    input wire logic             rst,
    mc_control_unit_if.master    bus
);

    localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t               r_state;
    state_t               w_state_nxt;
    cls_t                 r_cls;
    cls_t                 w_cls_dec;
    logic [c_WAIT_W-1:0]  r_wait;
    logic                 r_err_illegal;
    logic                 r_err_timeout;
    logic [CNT_W-1:0]     r_count;

    logic                 w_timeout;
    logic                 w_retire;
    logic                 w_set_ill;
    logic                 w_set_to;
    logic                 w_mem_req;
    logic                 w_mem_we;
    logic                 w_ir_write;
    logic                 w_pc_write;
    logic                 w_branch;
    logic                 w_alu_src;
    logic [ALUOP_W-1:0]   w_aluop;
    logic                 w_reg_write;
    logic                 w_mem_to_reg;

    instr_class_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .i_opcode (bus.opcode),
        .o_cls    (w_cls_dec)
    );

    // The limit is hit on the wait cycle that would bring the count to MEM_TIMEOUT;
    // a ready arriving in that same cycle still completes normally.
    assign w_timeout = ((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ready
                       && (r_wait == c_WAIT_W'(MEM_TIMEOUT - 1));

    // Next-state and Moore strobe decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_retire     = 1'b0;
        w_set_ill    = 1'b0;
        w_set_to     = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_alu_src    = 1'b0;
        w_aluop      = c_ALUOP_ADD;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write  = 1'b1;
                    w_state_nxt = S_DECODE;
                end else if (w_timeout) begin
                    w_set_to    = 1'b1;
                    w_state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                if (bus.opcode == HALT_OPCODE) begin
                    w_state_nxt = S_HALT;
                end else if (w_cls_dec == CLS_ILL) begin
                    w_set_ill   = 1'b1;
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_cls)
                    CLS_R:               w_aluop = c_ALUOP_R;
                    CLS_I:     begin w_alu_src = 1'b1; w_aluop = c_ALUOP_I;   end
                    CLS_LOAD,
                    CLS_STORE: begin w_alu_src = 1'b1; w_aluop = c_ALUOP_ADD; end
                    CLS_BR,
                    CLS_JAL:   begin w_branch  = 1'b1; w_aluop = c_ALUOP_BR;  end
                    CLS_JALR:  begin w_branch  = 1'b1; w_alu_src = 1'b1; w_aluop = c_ALUOP_ADD; end
                    default:             w_aluop = c_ALUOP_ADD;
                endcase
                if (r_cls == CLS_BR) begin
                    w_pc_write  = 1'b1;
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if ((r_cls == CLS_LOAD) || (r_cls == CLS_STORE)) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (r_cls == CLS_STORE);
                w_alu_src = 1'b1;
                w_aluop   = c_ALUOP_ADD;
                if (bus.mem_ready) begin
                    if (r_cls == CLS_STORE) begin
                        w_pc_write  = 1'b1;
                        w_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (w_timeout) begin
                    w_set_to    = 1'b1;
                    w_state_nxt = S_HALT;
                end
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = (r_cls == CLS_LOAD);
                w_pc_write   = 1'b1;
                w_branch     = (r_cls == CLS_JAL) || (r_cls == CLS_JALR);
                w_retire     = 1'b1;
                w_state_nxt  = S_FETCH;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, instruction class, wait counter, sticky errors and retire count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cls         <= CLS_ILL;
            r_wait        <= '0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
            r_count       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_DECODE) r_cls <= w_cls_dec;
            // FETCH and MEM are only ever entered from a different state,
            // so any state change restarts the wait count.
            if (w_state_nxt != r_state) begin
                r_wait <= '0;
            end else if (((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ready) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_set_ill) r_err_illegal <= 1'b1;
            if (w_set_to)  r_err_timeout <= 1'b1;
            if (w_retire)  r_count       <= r_count + 1'b1;
        end
    end

    assign bus.mem_req     = w_mem_req;
    assign bus.mem_we      = w_mem_we;
    assign bus.ir_write    = w_ir_write;
    assign bus.pc_write    = w_pc_write;
    assign bus.branch      = w_branch;
    assign bus.alu_src     = w_alu_src;
    assign bus.aluop       = w_aluop;
    assign bus.reg_write   = w_reg_write;
    assign bus.mem_to_reg  = w_mem_to_reg;
    assign bus.busy        = (r_state != S_IDLE) && (r_state != S_HALT);
    assign bus.halted      = (r_state == S_HALT);
    assign bus.err_illegal = r_err_illegal;
    assign bus.err_timeout = r_err_timeout;
    assign bus.instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_control_unit
//  Purpose  : Self-checking bench for mc_control_unit. A trace generator
//             expands each instruction into its expected per-cycle strobes,
//             then the trace is replayed cycle by cycle against the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_unit;

    localparam logic [6:0] c_R    = 7'b0110011;
    localparam logic [6:0] c_I    = 7'b0010011;
    localparam logic [6:0] c_LD   = 7'b0000011;
    localparam logic [6:0] c_ST   = 7'b0100011;
    localparam logic [6:0] c_BR   = 7'b1100011;
    localparam logic [6:0] c_JAL  = 7'b1101111;
    localparam logic [6:0] c_JALR = 7'b1100111;

    typedef struct {
        logic        start;
        logic        rdy;
        logic [6:0]  op;
        logic [11:0] exp;
        logic [1:0]  err;
        logic [31:0] cnt;
        string       tag;
    } step_t;

    logic        clk;
    logic        rst;
    step_t       q[$];
    logic [31:0] m_cnt;
    logic [1:0]  m_err;      // {err_illegal, err_timeout}
    int          checks;
    int          fails;
    int          n_instr;
    logic [6:0]  ops[7];

    mc_control_unit_if bus ();

    mc_control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs the observable strobes in a fixed order.
    function automatic logic [11:0] v(input logic req, input logic we, input logic irw,
                                      input logic pcw, input logic br, input logic asrc,
                                      input logic [1:0] aop, input logic rw, input logic m2r,
                                      input logic bsy, input logic hlt);
        return {req, we, irw, pcw, br, asrc, aop, rw, m2r, bsy, hlt};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    task automatic push(input logic st, input logic rdy, input logic [6:0] op,
                        input logic [11:0] exp, input string tag);
        step_t s;
        s.start = st; s.rdy = rdy; s.op = op; s.exp = exp;
        s.err = m_err; s.cnt = m_cnt; s.tag = tag;
        q.push_back(s);
    endtask

    // Expected trace of one legal instruction: fw fetch wait cycles, mw memory wait cycles.
    task automatic gen(input logic [6:0] op, input int fw, input int mw);
        logic       ld, st, br, jj, asrc;
        logic [1:0] aop;
        string      t;
        ld   = (op == c_LD);
        st   = (op == c_ST);
        br   = (op == c_BR);
        jj   = (op == c_JAL) || (op == c_JALR);
        asrc = (op == c_I) || ld || st || (op == c_JALR);
        aop  = (op == c_R) ? 2'b10 : (op == c_I) ? 2'b11 :
               (br || op == c_JAL) ? 2'b01 : 2'b00;
        t = $sformatf("i%0d_op%b", n_instr, op);
        n_instr++;
        for (int i = 0; i < fw; i++)
            push(rbit(), 1'b0, rop(), v(1,0,0,0,0,0,2'b00,0,0,1,0), {t, "_fetchwait"});
        push(rbit(), 1'b1, rop(), v(1,0,1,0,0,0,2'b00,0,0,1,0), {t, "_fetch"});
        push(rbit(), rbit(), op, v(0,0,0,0,0,0,2'b00,0,0,1,0), {t, "_decode"});
        push(rbit(), rbit(), rop(), v(0,0,0,br,br || jj,asrc,aop,0,0,1,0), {t, "_exec"});
        if (br) m_cnt++;
        if (ld || st) begin
            for (int i = 0; i < mw; i++)
                push(rbit(), 1'b0, rop(), v(1,st,0,0,0,1,2'b00,0,0,1,0), {t, "_memwait"});
            push(rbit(), 1'b1, rop(), v(1,st,0,st,0,1,2'b00,0,0,1,0), {t, "_mem"});
            if (st) m_cnt++;
        end
        if (!br && !st) begin
            push(rbit(), rbit(), rop(), v(0,0,0,1,jj,0,2'b00,1,ld,1,0), {t, "_wb"});
            m_cnt++;
        end
    endtask

    // Replays the expected trace; inputs change 1 time unit after the edge, outputs are sampled on negedge.
    task automatic play();
        step_t       s;
        logic [11:0] obs;
        logic [33:0] obs2;
        while (q.size() > 0) begin
            s = q.pop_front();
            bus.start     = s.start;
            bus.mem_ready = s.rdy;
            bus.opcode    = s.op;
            @(negedge clk);
            obs = {bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.branch, bus.alu_src,
                   bus.aluop, bus.reg_write, bus.mem_to_reg, bus.busy, bus.halted};
            checks++;
            assert (obs === s.exp) else begin
                fails++;
                $error("FAIL %s strobes observed=%b expected=%b", s.tag, obs, s.exp);
            end
            obs2 = {bus.err_illegal, bus.err_timeout, bus.instr_count};
            checks++;
            assert (obs2 === {s.err, s.cnt}) else begin
                fails++;
                $error("FAIL %s err/count observed=%b/%0d expected=%b/%0d",
                       s.tag, obs2[33:32], obs2[31:0], s.err, s.cnt);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_cnt = '0;
        m_err = '0;
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        n_instr = 0;
        m_cnt   = '0;
        m_err   = '0;
        ops     = '{c_R, c_I, c_LD, c_ST, c_BR, c_JAL, c_JALR};
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode    = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state, then launch.
        push(1'b0, rbit(), rop(), '0, "reset_idle");
        push(1'b1, rbit(), rop(), '0, "idle_start");
        // Directed classes, then a random instruction stream.
        gen(c_R, 0, 0);
        gen(c_BR, 0, 0);
        gen(c_JAL, 0, 0);
        gen(c_LD, 0, 3);
        gen(c_ST, 1, 2);
        gen(c_I, 0, 0);
        gen(c_JALR, 2, 0);
        for (int i = 0; i < 40; i++)
            gen(ops[$urandom_range(0, 6)], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        // Stall the next fetch, then reset in the middle of it.
        push(1'b0, 1'b0, rop(), v(1,0,0,0,0,0,2'b00,0,0,1,0), "midfetch_a");
        push(1'b0, 1'b0, rop(), v(1,0,0,0,0,0,2'b00,0,0,1,0), "midfetch_b");
        play();
        bus.mem_ready = 1'b0;
        do_reset();
        push(1'b0, 1'b1, rop(), '0, "after_midfetch_rst");
        play();

        // Halt opcode: no error, start ignored.
        push(1'b1, rbit(), rop(), '0, "halt_start");
        push(1'b0, 1'b1, rop(), v(1,0,1,0,0,0,2'b00,0,0,1,0), "halt_fetch");
        push(1'b0, rbit(), 7'h7f, v(0,0,0,0,0,0,2'b00,0,0,1,0), "halt_decode");
        for (int i = 0; i < 3; i++)
            push(1'b1, rbit(), rop(), v(0,0,0,0,0,0,2'b00,0,0,0,1), "halt_hold");
        play();

        // Illegal opcode.
        do_reset();
        push(1'b1, rbit(), rop(), '0, "ill_start");
        push(1'b0, 1'b1, rop(), v(1,0,1,0,0,0,2'b00,0,0,1,0), "ill_fetch");
        push(1'b0, rbit(), 7'h00, v(0,0,0,0,0,0,2'b00,0,0,1,0), "ill_decode");
        m_err[1] = 1'b1;
        for (int i = 0; i < 3; i++)
            push(1'b1, rbit(), rop(), v(0,0,0,0,0,0,2'b00,0,0,0,1), "ill_halt");
        play();

        // Fetch timeout: 16 cycles without ready.
        do_reset();
        push(1'b1, 1'b0, rop(), '0, "to_start");
        for (int i = 0; i < 16; i++)
            push(1'b0, 1'b0, rop(), v(1,0,0,0,0,0,2'b00,0,0,1,0), $sformatf("to_wait%0d", i));
        m_err[0] = 1'b1;
        for (int i = 0; i < 3; i++)
            push(rbit(), rbit(), rop(), v(0,0,0,0,0,0,2'b00,0,0,0,1), "to_halt");
        play();

        // Ready on the last permitted cycle completes normally, in FETCH and in MEM.
        do_reset();
        push(1'b1, 1'b0, rop(), '0, "edge_start");
        gen(c_R, 15, 0);
        gen(c_LD, 0, 15);
        gen(c_ST, 15, 15);
        push(1'b0, 1'b0, rop(), v(1,0,0,0,0,0,2'b00,0,0,1,0), "edge_final");
        play();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
